// File: rtl/toothless_pkg.sv
// Shared types for the EX->WB skid stage: buffer state encoding and stored entry layout.
package toothless_pkg;

  localparam int EX_WB_DATA_W = 32;
  localparam int EX_WB_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ex_wb_state_e;

  typedef struct packed {
    logic [EX_WB_DATA_W-1:0] result;
    logic [EX_WB_ADDR_W-1:0] rd_addr;
    logic                    rd_we;
  } ex_wb_entry_t;

  function automatic logic [1:0] occupancy_of(ex_wb_state_e st);
    case (st)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ex_wb_stage.sv
// Two-entry skid buffer between ALU and writeback, with an optional forwarding tap
// on the head entry enabled by defining TOOTHLESS_EX_FWD_EN.
//
// state | meaning
// EMPTY | no entries held, head fields read as zero
// ONE   | head entry valid, tail slot free
// FULL  | head and tail valid, upstream stalled
module ex_wb_stage
  import toothless_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [DATA_WIDTH-1:0]     result_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_we_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_WIDTH-1:0]     result_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic                      fwd_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
  output logic [1:0]                occupancy_o
);

  ex_wb_state_e state_q, state_d;
  ex_wb_entry_t head_q, head_d;
  ex_wb_entry_t tail_q, tail_d;
  ex_wb_entry_t in_entry;
  logic         push, pop;

  // Writes to register 0 are architecturally discarded, so drop the enable on entry.
  always_comb begin
    in_entry         = '0;
    in_entry.result  = EX_WB_DATA_W'(result_i);
    in_entry.rd_addr = EX_WB_ADDR_W'(rd_addr_i);
    in_entry.rd_we   = rd_we_i && (rd_addr_i != '0);
  end

  // Both handshakes depend only on the state register, never on the opposite side's inputs.
  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: head_d = in_entry;
            2'b10: begin
              tail_d  = in_entry;
              state_d = FULL;
            end
            2'b01: begin
              head_d  = '0;
              state_d = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign result_o    = valid_o ? DATA_WIDTH'(head_q.result) : '0;
  assign rd_addr_o   = valid_o ? REG_ADDR_WIDTH'(head_q.rd_addr) : '0;
  assign rd_we_o     = valid_o && head_q.rd_we;
  assign occupancy_o = occupancy_of(state_q);

`ifdef TOOTHLESS_EX_FWD_EN
  assign fwd_valid_o = valid_o && rd_we_o;
  assign fwd_addr_o  = rd_addr_o;
  assign fwd_data_o  = result_o;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_addr_o  = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: vector table plus backpressure drain sequence.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush_i, valid_i, ready_i, rd_we_i;
  logic [31:0] result_i;
  logic [4:0]  rd_addr_i;
  logic        ready_o, valid_o, rd_we_o, fwd_valid_o;
  logic [31:0] result_o, fwd_data_o;
  logic [4:0]  rd_addr_o, fwd_addr_o;
  logic [1:0]  occupancy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ex_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
    .fwd_data_o(fwd_data_o), .occupancy_o(occupancy_o)
  );

  typedef struct {
    logic        rst, flush, vin, rdy;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  occ;
    logic [31:0] eres;
    logic [4:0]  erd;
    logic        ewe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic v, logic rdy,
                              logic [31:0] res, logic [4:0] rd, logic we,
                              logic [1:0] occ, logic [31:0] eres, logic [4:0] erd, logic ewe);
    vec_t t;
    t.rst = r; t.flush = f; t.vin = v; t.rdy = rdy;
    t.res = res; t.rd = rd; t.we = we;
    t.occ = occ; t.eres = eres; t.erd = erd; t.ewe = ewe;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(logic r, logic f, logic v, logic rdy, logic [31:0] res, logic [4:0] rd, logic we);
    rst = r; flush_i = f; valid_i = v; ready_i = rdy;
    result_i = res; rd_addr_i = rd; rd_we_i = we;
  endtask

  task automatic check_outputs(string tag, logic [1:0] occ, logic [31:0] eres, logic [4:0] erd, logic ewe);
    logic ev, er, efv;
    logic [4:0]  efa;
    logic [31:0] efd;
    ev = (occ != 2'd0);
    er = (occ != 2'd2);
`ifdef TOOTHLESS_EX_FWD_EN
    efv = ev && ewe;
    efa = erd;
    efd = eres;
`else
    efv = 1'b0;
    efa = '0;
    efd = '0;
`endif
    check({tag, ".occupancy"}, 32'(occupancy_o), 32'(occ));
    check({tag, ".valid_o"},   32'(valid_o),     32'(ev));
    check({tag, ".ready_o"},   32'(ready_o),     32'(er));
    check({tag, ".result_o"},  result_o,         eres);
    check({tag, ".rd_addr_o"}, 32'(rd_addr_o),   32'(erd));
    check({tag, ".rd_we_o"},   32'(rd_we_o),     32'(ewe));
    check({tag, ".fwd_valid"}, 32'(fwd_valid_o), 32'(efv));
    check({tag, ".fwd_addr"},  32'(fwd_addr_o),  32'(efa));
    check({tag, ".fwd_data"},  fwd_data_o,       efd);
  endtask

  initial begin
    logic [31:0] seen[$];
    int          cycles;

    drive(1, 0, 0, 0, 0, 0, 0);

    //            rst flu vin rdy  result        rd  we   occ  exp_res       erd ewe
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0,  0,   0, 32'h0,        0,  0)); // reset
    vecs.push_back(mk(0, 0, 1, 1, 32'h5,        3,  1,   1, 32'h5,        3,  1)); // single pass
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 1, 0, 32'hA,        1,  1,   1, 32'hA,        1,  1)); // backpressure
    vecs.push_back(mk(0, 0, 1, 0, 32'hB,        2,  1,   2, 32'hA,        1,  1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC,        3,  1,   2, 32'hA,        1,  1)); // push blocked
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   1, 32'hB,        2,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h11,       4,  1,   1, 32'h11,       4,  1)); // push+pop in ONE
    vecs.push_back(mk(0, 0, 1, 1, 32'h22,       5,  1,   1, 32'h22,       5,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h40,       6,  1,   1, 32'h40,       6,  1)); // flush while FULL
    vecs.push_back(mk(0, 0, 1, 0, 32'h41,       6,  1,   2, 32'h40,       6,  1));
    vecs.push_back(mk(0, 1, 1, 1, 32'h33,       9,  1,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   0, 32'h0,        0,  0)); // ready while empty
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 1,   1, 32'hFFFF_FFFF, 0, 0)); // x0 write
    vecs.push_back(mk(0, 0, 1, 1, 32'h77,       7,  1,   1, 32'h77,       7,  1));
    vecs.push_back(mk(0, 0, 1, 0, 32'h88,       8,  0,   2, 32'h77,       7,  1));
    vecs.push_back(mk(1, 0, 1, 1, 32'h99,       9,  1,   0, 32'h0,        0,  0)); // reset while FULL
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0,  0,   0, 32'h0,        0,  0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h90,       9,  1,   1, 32'h90,       9,  1)); // tail with we=0
    vecs.push_back(mk(0, 0, 1, 0, 32'h91,      10,  0,   2, 32'h90,       9,  1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   1, 32'h91,      10,  0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        0,  0,   0, 32'h0,        0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].rdy, vecs[i].res, vecs[i].rd, vecs[i].we);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].occ, vecs[i].eres, vecs[i].erd, vecs[i].ewe);
    end

    // Hold a full buffer under backpressure, then drain and confirm FIFO order.
    @(negedge clk); drive(0, 0, 1, 0, 32'h100, 1, 1);
    @(negedge clk); drive(0, 0, 1, 0, 32'h200, 2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 0, 32'h300 + 32'(k), 3, 1);
      check($sformatf("hold%0d.result_o", k), result_o, 32'h100);
      check($sformatf("hold%0d.ready_o", k), 32'(ready_o), 32'h0);
      check($sformatf("hold%0d.occupancy", k), 32'(occupancy_o), 32'h2);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 0);
    cycles = 0;
    while (valid_o && cycles < 6) begin
      seen.push_back(result_o);
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    check("drain.timeout", 32'(valid_o), 32'h0);
    check("drain.count", 32'(seen.size()), 32'h2);
    if (seen.size() >= 2) begin
      check("drain.first", seen[0], 32'h100);
      check("drain.second", seen[1], 32'h200);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
